// File: rtl/writeback_commit_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : writeback_commit_arbiter_pkg                                        |
// | Shared types/constants for the writeback commit arbiter.                    |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package writeback_commit_arbiter_pkg;

   localparam int NUM_WB_UNITS          = 4;
   localparam int MAX_IDS               = 8;
   localparam int PHYS_ADDR_BITS        = 6;
   localparam int MAX_POSSIBLE_REG_BITS = 32;

   typedef logic [$clog2(MAX_IDS)-1:0]      id_t;
   typedef logic [PHYS_ADDR_BITS-1:0]       phys_addr_t;
   typedef logic [$clog2(NUM_WB_UNITS)-1:0] wb_unit_idx_t;

   typedef struct packed {
      id_t                              id;
      logic                             valid;
      phys_addr_t                       phys_addr;
      logic [MAX_POSSIBLE_REG_BITS-1:0] data;
   } commit_packet_t;

endpackage
`default_nettype wire

// File: rtl/writeback_commit_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_rr_select                                                       |
// | Combinational round-robin picker: first request above ptr, wrapping.        |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module wb_rr_select #(
   parameter  int NUM_UNITS = 4,
   localparam int IDX_W     = $clog2(NUM_UNITS)
) (
   input  logic [NUM_UNITS-1:0] requests,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_UNITS-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 grant_valid
);

   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest so the unit right after ptr overwrites last.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = NUM_UNITS; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_UNITS);
         if (requests[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/writeback_commit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : writeback_commit_arbiter                                           |
// | Round-robin share of the register-file commit port between writeback units.|
// | Option : CVA5_WB_FIXED_PRIORITY_EN gives unit 0 absolute priority.          |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module writeback_commit_arbiter
   import writeback_commit_arbiter_pkg::*;
#(
   parameter int NUM_UNITS = NUM_WB_UNITS,
   parameter int ID_COUNT  = MAX_IDS
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              issue_valid,
   input  id_t                                               issue_id,
   input  phys_addr_t                                        issue_phys_addr,
   input  logic                                              wb_supress,
   input  logic [NUM_UNITS-1:0]                              unit_done,
   input  id_t  [NUM_UNITS-1:0]                              unit_id,
   input  logic [NUM_UNITS-1:0][MAX_POSSIBLE_REG_BITS-1:0]   unit_data,
   output logic [NUM_UNITS-1:0]                              unit_ack,
   output commit_packet_t                                    commit,
   output logic                                              wb_conflict
);

   localparam int               IDX_W     = $clog2(NUM_UNITS);
   localparam logic [IDX_W-1:0] LAST_UNIT = IDX_W'(NUM_UNITS - 1);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   commit_packet_t   commit_q, commit_d;
   logic             wb_conflict_q, wb_conflict_d;
   phys_addr_t       phys_table [ID_COUNT];

   logic [NUM_UNITS-1:0] eligible, rr_req, rr_grant, grant;
   logic [IDX_W-1:0]     rr_idx, grant_idx;
   logic                 rr_valid, grant_valid;
   id_t                  grant_id;
   phys_addr_t           grant_phys;

   assign eligible = (rst || wb_supress) ? '0 : unit_done;

`ifdef CVA5_WB_FIXED_PRIORITY_EN
   assign rr_req = eligible & ~NUM_UNITS'(1);
`else
   assign rr_req = eligible;
`endif

   wb_rr_select #(.NUM_UNITS(NUM_UNITS)) u_rr_select (
      .requests    (rr_req),
      .ptr         (ptr_q),
      .grant       (rr_grant),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   always_comb begin
      grant       = rr_grant;
      grant_idx   = rr_idx;
      grant_valid = rr_valid;
`ifdef CVA5_WB_FIXED_PRIORITY_EN
      if (eligible[0]) begin
         grant       = NUM_UNITS'(1);
         grant_idx   = '0;
         grant_valid = 1'b1;
      end
`endif
   end

   assign unit_ack = grant;

   // In fixed-priority mode unit 0 wins outside the rotation, so it never moves ptr.
   always_comb begin
      ptr_d = ptr_q;
`ifdef CVA5_WB_FIXED_PRIORITY_EN
      if (grant_valid && (grant_idx != '0)) ptr_d = grant_idx;
`else
      if (grant_valid) ptr_d = grant_idx;
`endif
   end

   assign grant_id   = unit_id[grant_idx];
   assign grant_phys = phys_table[grant_id];

   // Writes to x0 are acked but never reach the register file.
   always_comb begin
      commit_d           = '0;
      commit_d.id        = grant_id;
      commit_d.valid     = grant_valid && (grant_phys != '0);
      commit_d.phys_addr = grant_phys;
      commit_d.data      = unit_data[grant_idx];
      wb_conflict_d      = $countones(unit_done) > 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q         <= LAST_UNIT;
         commit_q      <= '0;
         wb_conflict_q <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         commit_q      <= commit_d;
         wb_conflict_q <= wb_conflict_d;
      end
   end

   always_ff @(posedge clk) begin
      if (issue_valid) phys_table[issue_id] <= issue_phys_addr;
   end

   assign commit      = commit_q;
   assign wb_conflict = wb_conflict_q;

   a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(unit_ack));
   a_ack_needs_done: assert property (@(posedge clk) disable iff (rst) (unit_ack & ~unit_done) == '0);
   a_no_issue_on_commit_id: assert property (@(posedge clk) disable iff (rst)
      !(issue_valid && grant_valid && (grant_id == issue_id)));

endmodule
`default_nettype wire
